// File: rtl/wb_regfile.sv
// Write-back register file: 8x16 regs, two bypassed combinational read ports, per-register pending-write scoreboard.
// Commit, scoreboard and retire counter update on the clock edge; no backpressure taken, ID stalls on rs_busy/rt_busy.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sw1_in,
  input  logic              sw5_in,
  input  logic              sw7_in,
  input  logic              writeOrder_in,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] link_pc,
  input  logic [DATA_W-1:0] imm,
  input  logic              issue_valid,
  input  logic              issue_writes,
  input  logic [2:0]        issue_dest,
  input  logic [2:0]        rs_addr,
  input  logic [2:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [15:0]       retire_count,
  output logic              sb_overflow
);

  logic [DATA_W-1:0] regs     [REG_N];
  logic [1:0]        pend     [REG_N];
  logic [1:0]        pend_nxt [REG_N];
  logic [REG_N-1:0]  inc_v;
  logic [REG_N-1:0]  dec_v;
  logic              ovf_set;
  logic [DATA_W-1:0] wb_dat;
  logic              rs_byp;
  logic              rt_byp;

  always_comb begin
    wb_dat = alu_result;
    if (sw7_in)      wb_dat = imm;
    else if (sw5_in) wb_dat = link_pc;
    else if (sw1_in) wb_dat = load_data;
  end

  assign rs_byp  = writeOrder_in && (wb_addr == rs_addr);
  assign rt_byp  = writeOrder_in && (wb_addr == rt_addr);
  assign rs_data = rs_byp ? wb_dat : regs[rs_addr];
  assign rt_data = rt_byp ? wb_dat : regs[rt_addr];
  // A single outstanding write that commits this cycle is satisfied by the bypass.
  assign rs_busy = (pend[rs_addr] != 2'd0) && !(rs_byp && (pend[rs_addr] == 2'd1));
  assign rt_busy = (pend[rt_addr] != 2'd0) && !(rt_byp && (pend[rt_addr] == 2'd1));

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < REG_N; i++) begin
      inc_v[i] = issue_valid && issue_writes && (issue_dest == 3'(i));
      dec_v[i] = writeOrder_in && (wb_addr == 3'(i));
    end
  end

  always_comb begin
    pend_nxt = pend;
    ovf_set  = 1'b0;
    for (int i = 0; i < REG_N; i++) begin
      if (inc_v[i] && !dec_v[i]) begin
        if (pend[i] == 2'd3) ovf_set = 1'b1;
        else                 pend_nxt[i] = pend[i] + 2'd1;
      end else if (dec_v[i] && !inc_v[i] && (pend[i] != 2'd0)) begin
        pend_nxt[i] = pend[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
        pend[i] <= 2'd0;
      end
      retire_count <= 16'd0;
      sb_overflow  <= 1'b0;
    end else begin
      if (writeOrder_in) begin
        regs[wb_addr] <= wb_dat;
        retire_count  <= retire_count + 16'd1;
      end
      pend        <= pend_nxt;
      sb_overflow <= sb_overflow | ovf_set;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus random bench for wb_regfile against a behavioural model of regs, pending counts and retire count.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic        sw1_in, sw5_in, sw7_in, writeOrder_in;
  logic [2:0]  wb_addr;
  logic [15:0] alu_result, load_data, link_pc, imm;
  logic        issue_valid, issue_writes;
  logic [2:0]  issue_dest, rs_addr, rt_addr;
  logic [15:0] rs_data, rt_data;
  logic        rs_busy, rt_busy;
  logic [15:0] retire_count;
  logic        sb_overflow;

  int total = 0;
  int bad   = 0;

  int m_regs [8];
  int m_pend [8];
  int m_cnt;
  bit m_ovf;

  wb_regfile #(.DATA_W(16), .REG_N(8)) dut (
    .clock(clock), .reset(reset),
    .sw1_in(sw1_in), .sw5_in(sw5_in), .sw7_in(sw7_in),
    .writeOrder_in(writeOrder_in), .wb_addr(wb_addr),
    .alu_result(alu_result), .load_data(load_data), .link_pc(link_pc), .imm(imm),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .retire_count(retire_count), .sb_overflow(sb_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_sel();
    if (sw7_in) return int'(imm);
    if (sw5_in) return int'(link_pc);
    if (sw1_in) return int'(load_data);
    return int'(alu_result);
  endfunction

  function automatic int exp_data(input logic [2:0] a);
    if (writeOrder_in && wb_addr == a) return m_sel();
    return m_regs[a];
  endfunction

  // Outstanding writes minus the one (if any) landing right now through the bypass.
  function automatic int exp_busy(input logic [2:0] a);
    int credit;
    credit = (writeOrder_in && wb_addr == a) ? 1 : 0;
    return (m_pend[a] - credit > 0) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic m_commit();
    int d [8];
    for (int i = 0; i < 8; i++) d[i] = 0;
    if (issue_valid && issue_writes) d[issue_dest] += 1;
    if (writeOrder_in) begin
      d[wb_addr] -= 1;
      m_regs[wb_addr] = m_sel();
      m_cnt = (m_cnt + 1) % 65536;
    end
    for (int i = 0; i < 8; i++) begin
      if (d[i] > 0) begin
        if (m_pend[i] == 3) m_ovf = 1'b1;
        else m_pend[i] += 1;
      end else if (d[i] < 0) begin
        m_pend[i] = (m_pend[i] > 0) ? m_pend[i] - 1 : 0;
      end
    end
  endtask

  task automatic clr();
    sw1_in = 0; sw5_in = 0; sw7_in = 0; writeOrder_in = 0;
    wb_addr = 0; alu_result = 0; load_data = 0; link_pc = 0; imm = 0;
    issue_valid = 0; issue_writes = 0; issue_dest = 0;
    rs_addr = 0; rt_addr = 0;
  endtask

  task automatic tick(input string tag, input bit do_chk);
    #1;
    if (do_chk) begin
      chk({tag, "_rs_data"}, 32'(rs_data), 32'(exp_data(rs_addr)));
      chk({tag, "_rt_data"}, 32'(rt_data), 32'(exp_data(rt_addr)));
      chk({tag, "_rs_busy"}, 32'(rs_busy), 32'(exp_busy(rs_addr)));
      chk({tag, "_rt_busy"}, 32'(rt_busy), 32'(exp_busy(rt_addr)));
      chk({tag, "_retire"},  32'(retire_count), 32'(m_cnt));
      chk({tag, "_ovf"},     32'(sb_overflow), 32'(m_ovf));
    end
    @(posedge clock);
    m_commit();
    @(negedge clock);
  endtask

  initial begin
    clr();
    reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    rs_addr = 3'd3; rt_addr = 3'd7;
    #1;
    chk("rst_rs_data", 32'(rs_data), 32'h0);
    chk("rst_rt_data", 32'(rt_data), 32'h0);
    chk("rst_busy", 32'({rs_busy, rt_busy}), 32'h0);
    chk("rst_retire", 32'(retire_count), 32'h0);
    chk("rst_ovf", 32'(sb_overflow), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Source priority
    clr(); writeOrder_in = 1; wb_addr = 2; sw1_in = 1; sw7_in = 1;
    imm = 16'h00AA; load_data = 16'h5555; alu_result = 16'h7777; rs_addr = 2;
    tick("prio_imm", 1);
    clr(); rs_addr = 2; #1;
    chk("prio_r2_imm", 32'(rs_data), 32'h00AA);
    writeOrder_in = 1; wb_addr = 2; alu_result = 16'h0F0F; load_data = 16'h1111;
    tick("prio_alu", 1);
    clr(); sw5_in = 1; link_pc = 16'hBEEF; wb_addr = 2; rs_addr = 2;
    tick("prio_nowrite", 1);
    #1;
    chk("prio_r2_hold", 32'(rs_data), 32'h0F0F);

    // Bypass
    clr(); writeOrder_in = 1; wb_addr = 5; alu_result = 16'h1111;
    tick("byp_pre", 1);
    clr(); writeOrder_in = 1; wb_addr = 5; alu_result = 16'h2222; rs_addr = 5; rt_addr = 5;
    #1;
    chk("byp_rs", 32'(rs_data), 32'h2222);
    chk("byp_rt", 32'(rt_data), 32'h2222);
    tick("byp", 1);
    clr(); rs_addr = 5; #1;
    chk("byp_array", 32'(rs_data), 32'h2222);

    // Scoreboard on r4
    clr(); issue_valid = 1; issue_writes = 1; issue_dest = 4;
    tick("sb_iss1", 1);
    tick("sb_iss2", 1);
    clr(); rs_addr = 4; #1;
    chk("sb_pend2_busy", 32'(rs_busy), 32'h1);
    writeOrder_in = 1; wb_addr = 4; alu_result = 16'h4444; #1;
    chk("sb_wb1_busy", 32'(rs_busy), 32'h1);
    tick("sb_wb1", 1);
    alu_result = 16'h4545; #1;
    chk("sb_wb2_busy", 32'(rs_busy), 32'h0);
    chk("sb_wb2_data", 32'(rs_data), 32'h4545);
    tick("sb_wb2", 1);
    clr(); issue_valid = 1; issue_writes = 1; issue_dest = 4; rs_addr = 4;
    tick("sb_iss3", 1);
    writeOrder_in = 1; wb_addr = 4; alu_result = 16'h4646;
    tick("sb_both", 1);
    clr(); rs_addr = 4; #1;
    chk("sb_both_busy", 32'(rs_busy), 32'h1);
    writeOrder_in = 1; wb_addr = 4;
    tick("sb_drain", 1);
    clr(); rs_addr = 4; #1;
    chk("sb_drained", 32'(rs_busy), 32'h0);

    // Saturation and underflow
    clr(); issue_valid = 1; issue_writes = 1; issue_dest = 1; rs_addr = 1;
    repeat (3) tick("sat_iss", 1);
    #1;
    chk("sat_before", 32'(sb_overflow), 32'h0);
    tick("sat_iss4", 1);
    #1;
    chk("sat_after", 32'(sb_overflow), 32'h1);
    clr(); writeOrder_in = 1; wb_addr = 1; rs_addr = 1;
    repeat (3) tick("sat_drain", 1);
    clr(); rs_addr = 1; #1;
    chk("sat_drained_busy", 32'(rs_busy), 32'h0);
    chk("sat_sticky", 32'(sb_overflow), 32'h1);
    clr(); writeOrder_in = 1; wb_addr = 6; alu_result = 16'h6666; rt_addr = 6;
    tick("uf_wb", 1);
    clr(); rs_addr = 6; #1;
    chk("uf_data", 32'(rs_data), 32'h6666);
    chk("uf_busy", 32'(rs_busy), 32'h0);
    issue_valid = 1; issue_writes = 1; issue_dest = 6;
    tick("uf_iss", 1);
    clr(); rs_addr = 6; writeOrder_in = 1; wb_addr = 6; alu_result = 16'h6767; #1;
    chk("uf_pend1_credit", 32'(rs_busy), 32'h0);
    tick("uf_wb2", 1);

    // Reset mid-stream
    clr(); writeOrder_in = 1; wb_addr = 3; alu_result = 16'h1234;
    tick("mr_load", 1);
    clr(); issue_valid = 1; issue_writes = 1; issue_dest = 3;
    tick("mr_iss", 1);
    clr(); rs_addr = 3; rt_addr = 3; #1;
    chk("mr_pre_data", 32'(rs_data), 32'h1234);
    chk("mr_pre_busy", 32'(rs_busy), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_data", 32'(rs_data), 32'h0);
    chk("mr_retire", 32'(retire_count), 32'h0);
    chk("mr_busy", 32'({rs_busy, rt_busy}), 32'h0);
    chk("mr_ovf", 32'(sb_overflow), 32'h0);
    writeOrder_in = 1; wb_addr = 3; alu_result = 16'hABCD;
    @(posedge clock);
    #1;
    writeOrder_in = 0;
    #1;
    chk("mr_inflight", 32'(rs_data), 32'h0);
    chk("mr_inflight_cnt", 32'(retire_count), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    m_reset();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      sw1_in = 1'($urandom); sw5_in = 1'($urandom); sw7_in = 1'($urandom);
      writeOrder_in = 1'($urandom);
      wb_addr = 3'($urandom); alu_result = 16'($urandom); load_data = 16'($urandom);
      link_pc = 16'($urandom); imm = 16'($urandom);
      issue_valid = 1'($urandom); issue_writes = 1'($urandom); issue_dest = 3'($urandom);
      rs_addr = 3'($urandom); rt_addr = 3'($urandom);
      tick("rand", 1);
    end

    // Retire counter wrap
    clr();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_reset();
    writeOrder_in = 1;
    for (int n = 0; n < 65535; n++) begin
      wb_addr = 3'($urandom); alu_result = 16'($urandom);
      tick("wrap_fill", 0);
    end
    writeOrder_in = 0; #1;
    chk("wrap_ffff", 32'(retire_count), 32'hFFFF);
    writeOrder_in = 1; wb_addr = 0; alu_result = 16'h0C0C;
    tick("wrap_last", 1);
    writeOrder_in = 0; #1;
    chk("wrap_zero", 32'(retire_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
